// File: rtl/pc_pkg.sv
// ============================================================================
// Module  : pc_pkg
// Purpose : Shared constants and the mode encoding for the program counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pc_pkg;

  localparam int PC_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_INC   = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_STALL = 2'b11
  } pc_mode_e;

  // Stall outranks load, and load outranks increment.
  function automatic pc_mode_e pc_decode(input logic stall, input logic load, input logic inc);
    if (stall)     return MODE_STALL;
    else if (load) return MODE_LOAD;
    else if (inc)  return MODE_INC;
    else           return MODE_HOLD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/program_counter_if.sv
// ============================================================================
// Module  : program_counter_if
// Purpose : Control and address bundle between the sequencer and the PC stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface program_counter_if #(
  parameter int WIDTH = 8
);
  logic             stall;
  logic             load;
  logic [WIDTH-1:0] load_addr;
  logic             inc;
  logic             wrap_clr;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] pc_prev;
  logic             wrap;

  modport master (
    output stall, load, load_addr, inc, wrap_clr,
    input  pc, pc_plus, pc_prev, wrap
  );

  modport slave (
    input  stall, load, load_addr, inc, wrap_clr,
    output pc, pc_plus, pc_prev, wrap
  );
endinterface

`default_nettype wire

// File: rtl/dff_ar.sv
// ============================================================================
// Module  : dff_ar
// Purpose : Enabled D flip-flop bank with asynchronous active-high reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dff_ar #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_en,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       o_q <= RESET_VAL;
    else if (i_en) o_q <= i_d;
  end

endmodule

`default_nettype wire

// File: rtl/program_counter.sv
// ============================================================================
// Module  : program_counter
// Purpose : Fetch-address register with increment, load, stall and wrap flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_counter
  import pc_pkg::*;
#(
  parameter int          WIDTH     = PC_WIDTH_DEFAULT,
  parameter logic [31:0] RESET_VAL = 32'd0,
  parameter int unsigned STEP      = 1
) (
  input wire logic          clk,
  input wire logic          rst,
  program_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_reset_val = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH:0]   c_step      = (WIDTH+1)'(STEP);

  pc_mode_e         w_mode;
  logic [WIDTH:0]   w_sum;
  logic             w_pc_en;
  logic [WIDTH-1:0] w_pc_d;
  logic             w_wrap_en;
  logic             w_wrap_d;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pc_prev;
  logic             r_wrap;

  assign w_mode = pc_decode(bus.stall, bus.load, bus.inc);
  // One extra bit keeps the carry-out that drives the wrap flag.
  assign w_sum  = {1'b0, r_pc} + c_step;

  always_comb begin
    w_pc_en   = (w_mode == MODE_LOAD) || (w_mode == MODE_INC);
    w_pc_d    = (w_mode == MODE_LOAD) ? bus.load_addr : w_sum[WIDTH-1:0];
    w_wrap_en = (w_mode != MODE_STALL);
    // A wrapping increment wins over a simultaneous clear.
    w_wrap_d  = ((w_mode == MODE_INC) && w_sum[WIDTH]) || (r_wrap && !bus.wrap_clr);
  end

  dff_ar #(.WIDTH(WIDTH), .RESET_VAL(c_reset_val)) u_pc (
    .clk(clk), .rst(rst), .i_en(w_pc_en), .i_d(w_pc_d), .o_q(r_pc)
  );

  dff_ar #(.WIDTH(WIDTH), .RESET_VAL(c_reset_val)) u_pc_prev (
    .clk(clk), .rst(rst), .i_en(w_pc_en), .i_d(r_pc), .o_q(r_pc_prev)
  );

  dff_ar #(.WIDTH(1), .RESET_VAL(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .i_en(w_wrap_en), .i_d(w_wrap_d), .o_q(r_wrap)
  );

  assign bus.pc      = r_pc;
  assign bus.pc_plus = w_sum[WIDTH-1:0];
  assign bus.pc_prev = r_pc_prev;
  assign bus.wrap    = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_program_counter.sv
// ============================================================================
// Module  : tb_program_counter
// Purpose : Drives STEP=1 and STEP=4 program counters against an address model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_program_counter;
  import pc_pkg::*;

  localparam int W = 8;
  localparam int MOD = 1 << W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_counter_if #(.WIDTH(W)) bus1 ();
  program_counter_if #(.WIDTH(W)) bus4 ();

  assign bus4.stall     = bus1.stall;
  assign bus4.load      = bus1.load;
  assign bus4.load_addr = bus1.load_addr;
  assign bus4.inc       = bus1.inc;
  assign bus4.wrap_clr  = bus1.wrap_clr;

  program_counter #(.WIDTH(W), .RESET_VAL(32'd0), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );
  program_counter #(.WIDTH(W), .RESET_VAL(32'h100), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );

  int unsigned step_amt [2] = '{1, 4};
  int unsigned m_pc     [2];
  int unsigned m_prev   [2];
  bit          m_wrap   [2];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Both instances reset to zero (0x100 truncates to 8'h00).
  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_prev[k] = 0; m_wrap[k] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input bit s, input bit l, input int unsigned la,
                                     input bit i, input bit wc);
    pc_mode_e mode;
    int unsigned sum;
    mode = s ? MODE_STALL : (l ? MODE_LOAD : (i ? MODE_INC : MODE_HOLD));
    for (int k = 0; k < 2; k++) begin
      sum = m_pc[k] + step_amt[k];
      case (mode)
        MODE_LOAD: begin
          m_prev[k] = m_pc[k]; m_pc[k] = la;
          if (wc) m_wrap[k] = 1'b0;
        end
        MODE_INC: begin
          m_prev[k] = m_pc[k]; m_pc[k] = sum % MOD;
          if (sum >= MOD) m_wrap[k] = 1'b1;
          else if (wc)    m_wrap[k] = 1'b0;
        end
        MODE_HOLD: if (wc) m_wrap[k] = 1'b0;
        default: ;
      endcase
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, " s1 pc"},      32'(bus1.pc),      m_pc[0]);
    check({tag, " s1 pc_plus"}, 32'(bus1.pc_plus), (m_pc[0] + 1) % MOD);
    check({tag, " s1 pc_prev"}, 32'(bus1.pc_prev), m_prev[0]);
    check({tag, " s1 wrap"},    32'(bus1.wrap),    32'(m_wrap[0]));
    check({tag, " s4 pc"},      32'(bus4.pc),      m_pc[1]);
    check({tag, " s4 pc_plus"}, 32'(bus4.pc_plus), (m_pc[1] + 4) % MOD);
    check({tag, " s4 pc_prev"}, 32'(bus4.pc_prev), m_prev[1]);
    check({tag, " s4 wrap"},    32'(bus4.wrap),    32'(m_wrap[1]));
  endtask

  task automatic drive(input bit s, input bit l, input int unsigned la, input bit i, input bit wc);
    bus1.stall = s; bus1.load = l; bus1.load_addr = la[W-1:0]; bus1.inc = i; bus1.wrap_clr = wc;
  endtask

  // Inputs change at posedge+1; outputs are checked 1 time unit after the edge.
  task automatic tick(input string tag);
    bit s, l, i, wc;
    int unsigned la;
    s = bus1.stall; l = bus1.load; la = 32'(bus1.load_addr); i = bus1.inc; wc = bus1.wrap_clr;
    @(posedge clk);
    model_edge(s, l, la, i, wc);
    #1;
    check_all(tag);
  endtask

  task automatic step(input string tag, input bit s, input bit l, input int unsigned la,
                      input bit i, input bit wc);
    drive(s, l, la, i, wc);
    tick(tag);
  endtask

  task automatic mid_cycle_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all({tag, " async"});
    @(posedge clk);
    #1 check_all({tag, " held"});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #2 check_all("reset");
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    check_all("post-reset");

    step("load37", 0, 1, 'h37, 0, 0);
    drive(0, 1, 'h99, 1, 0);
    mid_cycle_reset("rst37");
    step("idle1", 0, 0, 0, 0, 0);
    step("idle2", 0, 0, 0, 0, 0);

    for (int n = 0; n < 4; n++) step("inc", 0, 0, 0, 1, 0);

    step("load_over_inc", 0, 1, 'hA0, 1, 0);
    step("inc_after_load", 0, 0, 0, 1, 0);

    step("loadFE", 0, 1, 'hFE, 0, 0);
    step("incFE", 0, 0, 0, 1, 0);
    step("incFF", 0, 0, 0, 1, 0);
    step("idle_wrap", 0, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) step("stall", 1, 1, 'h55, 1, 1);
    step("wrap_clr", 0, 0, 0, 0, 1);

    step("loadFF", 0, 1, 'hFF, 0, 0);
    step("set_beats_clr", 0, 0, 0, 1, 1);
    step("clr", 0, 0, 0, 0, 1);
    step("loadFC", 0, 1, 'hFC, 0, 0);
    step("incFC", 0, 0, 0, 1, 0);
    step("same_load", 0, 1, 32'(bus1.pc), 0, 0);

    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        drive(0, 0, 0, 1, 0);
        mid_cycle_reset("rst_rand");
      end
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 255),
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/program_counter.md
Name: program_counter

Overview:
- Address-sequencing register stage of the processor datapath.
- Sits directly downstream of the flip-flop primitives. It is a WIDTH-bit bank of edge-triggered state with next-state logic for increment, load and stall.
- Produces the fetch address, its precomputed successor, the previous address (link value) and a sticky wrap-around flag.

Parameters:
- WIDTH, 8, address width in bits (legal range 2..32).
- RESET_VAL, 0, value of pc after reset. It is truncated to WIDTH bits.
- STEP, 1, increment amount. Legal range is 1..2^(WIDTH-1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold all state this cycle. Takes priority over load and inc.
- load  input  1  load pc from load_addr (branch/jump).
- load_addr  input  WIDTH  target address for load.
- inc  input  1  advance pc by STEP.
- wrap_clr  input  1  clear sticky wrap flag.
- pc  output  WIDTH  current fetch address (registered).
- pc_plus  output  WIDTH  combinational pc+STEP, modulo 2^WIDTH.
- pc_prev  output  WIDTH  value pc held before its most recent change (registered).
- wrap  output  1  sticky flag: an increment overflowed past 2^WIDTH-1.

Behaviour:
- Reset: rst=1 forces the following immediately, without waiting for clk, and holds them while rst stays high:
  - pc=RESET_VAL
  - pc_prev=RESET_VAL
  - wrap=0
- Release of rst is synchronous in effect. The first update happens on the first rising edge with rst=0.
- Per-edge priority, highest first: rst, stall, load, inc, hold.
  - stall=1: pc, pc_prev and wrap hold, regardless of load/inc/wrap_clr. wrap_clr is ignored during stall.
  - load=1 (stall=0): pc<=load_addr and pc_prev<=pc. inc is ignored and wrap is not set by load.
  - inc=1 (load=0, stall=0): pc<=pc_plus and pc_prev<=pc.
  - Otherwise: pc and pc_prev hold.
- pc_prev updates only on edges where pc is written (load or inc). A load of the same value still counts as a write.
- Arithmetic:
  - pc_plus = (pc + STEP) mod 2^WIDTH, computed in WIDTH+1 bits.
  - ovf = carry-out bit WIDTH of that sum.
- wrap next-state (when stall=0):
  - set if an inc is taken and ovf=1;
  - else cleared if wrap_clr=1;
  - else hold.
  - If set and clear occur on the same edge, set wins.
- Latency:
  - pc reflects load/inc one edge after the request.
  - pc_plus follows pc combinationally.
  - wrap asserts on the same edge that pc wraps.
- Boundaries:
  - pc=2^WIDTH-STEP with inc gives pc=0 and wrap=1.
  - pc=2^WIDTH-1 with STEP=1 gives pc=0.
  - load_addr beyond range cannot occur because the port is WIDTH bits.
- Reset mid-operation: rst asserted in any cycle discards pending load/inc. Outputs reach reset values asynchronously, before the next edge.
- No X propagation from undriven controls is required. The bench drives all inputs.

Decomposition:
- Shared package pc_pkg:
  - PC_WIDTH_DEFAULT=8.
  - Mode encoding constants MODE_HOLD=2'b00, MODE_INC=2'b01, MODE_LOAD=2'b10, MODE_STALL=2'b11.
  - The priority encoder produces these constants; the next-state mux and the bench monitor both use them.
- One sub-module, dff_ar:
  - A WIDTH-parameterised bank of D flip-flops with asynchronous active-high reset to a parameter value, plus an enable.
  - Instantiated three times: pc (WIDTH), pc_prev (WIDTH) and wrap (1).
  - The top level holds only mode decode, the adder and the next-state muxes.

Test Plan:
- Reset: assert rst mid-cycle with pc=8'h37 -> pc=8'h00, pc_prev=8'h00 and wrap=0 before the next edge. Release, idle 2 cycles -> values hold.
- Increment: inc=1 for 4 edges from 0 -> pc=1,2,3,4; pc_prev=0,1,2,3; pc_plus=pc+1 each cycle.
- Load vs inc: load=1, inc=1, load_addr=8'hA0 -> pc=8'hA0, pc_prev=prior pc. Next edge inc only -> pc=8'hA1.
- Stall priority: stall=1 with load=1, load_addr=8'h55 and wrap_clr=1, wrap=1 -> pc, pc_prev and wrap all unchanged for 3 cycles.
- Wrap: load 8'hFE, then inc, then inc -> pc=8'hFF with wrap=0, then pc=8'h00 with wrap=1. Idle -> wrap stays 1. wrap_clr -> wrap=0.
- Set-beats-clear: pc=8'hFF, inc=1 and wrap_clr=1 on the same edge -> pc=8'h00, wrap=1. STEP=4 variant: pc=8'hFC with inc -> pc=8'h00, wrap=1.
